// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B over three NxN stores.
// One MAC, inner-product order k, raster order over (i, j).
module matmul_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 10,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  a_en_ReadMat,
  output logic [ADDR_WIDTH-1:0] a_rowAddr,
  output logic [ADDR_WIDTH-1:0] a_colAddr,
  input  logic [DATA_WIDTH-1:0] a_readData,
  output logic                  b_en_ReadMat,
  output logic [ADDR_WIDTH-1:0] b_rowAddr,
  output logic [ADDR_WIDTH-1:0] b_colAddr,
  input  logic [DATA_WIDTH-1:0] b_readData,
  output logic                  c_en_WriteMat,
  output logic [ADDR_WIDTH-1:0] c_rowAddr,
  output logic [ADDR_WIDTH-1:0] c_colAddr,
  output logic [ACC_WIDTH-1:0]  c_writeData
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, WRITE, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] i, j, k;
  logic [ADDR_WIDTH-1:0] i_n, j_n, k_n;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  mac_vld, mac_first;
  logic [2*DATA_WIDTH-1:0] prod;

  assign prod = {{DATA_WIDTH{1'b0}}, a_readData}
              * {{DATA_WIDTH{1'b0}}, b_readData};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      mac_vld   <= 1'b0;
      mac_first <= 1'b0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
      if (abort && state != IDLE) begin
        acc       <= '0;
        mac_vld   <= 1'b0;
        mac_first <= 1'b0;
      end else begin
        mac_vld   <= (state == READ);
        mac_first <= (state == READ) && (k == '0);
        if (mac_vld)
          acc <= (mac_first ? '0 : acc) + ACC_WIDTH'(prod);
      end
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = READ;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
        end
      end
      READ: begin
        if (k == LAST) begin
          state_n = WAIT;
          k_n     = '0;
        end else begin
          k_n = k + ONE;
        end
      end
      WAIT: state_n = WRITE;
      WRITE: begin
        state_n = READ;
        if (j == LAST) begin
          j_n = '0;
          if (i == LAST) begin
            i_n     = '0;
            state_n = DONE;
          end else begin
            i_n = i + ONE;
          end
        end else begin
          j_n = j + ONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // abort beats everything except the idle case
    if (abort && state != IDLE) begin
      state_n = IDLE;
      i_n     = '0;
      j_n     = '0;
      k_n     = '0;
    end
  end

  always_comb begin
    busy          = (state == READ) || (state == WAIT) || (state == WRITE);
    done          = (state == DONE);
    a_en_ReadMat  = (state == READ);
    b_en_ReadMat  = (state == READ);
    c_en_WriteMat = (state == WRITE);
    a_rowAddr     = a_en_ReadMat ? i : '0;
    a_colAddr     = a_en_ReadMat ? k : '0;
    b_rowAddr     = b_en_ReadMat ? k : '0;
    b_colAddr     = b_en_ReadMat ? j : '0;
    c_rowAddr     = c_en_WriteMat ? i : '0;
    c_colAddr     = c_en_WriteMat ? j : '0;
    c_writeData   = c_en_WriteMat ? acc : '0;
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: timeline model driven by cycles since start,
// matrix stores modelled as arrays with one-cycle read latency.
module tb_matmul_ctrl;

  localparam int DW = 8;
  localparam int N  = 10;
  localparam int AW = 4;
  localparam int CW = 20;
  localparam int EL = N + 2;
  localparam int D  = N * N * EL + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  logic a_en, b_en, c_en;
  logic [AW-1:0] a_row, a_col, b_row, b_col, c_row, c_col;
  logic [DW-1:0] a_rd = '0;
  logic [DW-1:0] b_rd = '0;
  logic [CW-1:0] c_wd;

  logic [DW-1:0] am [N][N];
  logic [DW-1:0] bm [N][N];
  logic [CW-1:0] cm [N][N];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  int t = 0;
  int wr_cnt, done_cnt, busy_cnt, done_at;

  matmul_ctrl #(
    .DATA_WIDTH(DW), .N(N), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .a_en_ReadMat(a_en), .a_rowAddr(a_row), .a_colAddr(a_col),
    .a_readData(a_rd),
    .b_en_ReadMat(b_en), .b_rowAddr(b_row), .b_colAddr(b_col),
    .b_readData(b_rd),
    .c_en_WriteMat(c_en), .c_rowAddr(c_row), .c_colAddr(c_col),
    .c_writeData(c_wd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_en) a_rd <= am[a_row][a_col];
    if (b_en) b_rd <= bm[b_row][b_col];
  end

  // t = cycles since the accepted start; 0 means idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else if (t == 0) t <= (start && !abort) ? 1 : 0;
    else if (abort || t == D) t <= 0;
    else t <= t + 1;
  end

  function automatic logic [CW-1:0] exp_c(int i, int j);
    int s = 0;
    for (int kk = 0; kk < N; kk++) s += int'(am[i][kk]) * int'(bm[kk][j]);
    return CW'(s);
  endfunction

  function automatic logic [48:0] exp_out(int tt);
    logic bz = 0, dn = 0, re = 0, we = 0;
    logic [AW-1:0] ar = 0, ac = 0, br = 0, bc = 0, cr = 0, cc = 0;
    logic [CW-1:0] cd = 0;
    int e, p, ii, jj;
    if (tt == D) dn = 1;
    else if (tt > 0) begin
      e  = (tt - 1) / EL;
      p  = (tt - 1) % EL;
      ii = e / N;
      jj = e % N;
      bz = 1;
      if (p < N) begin
        re = 1;
        ar = AW'(ii); ac = AW'(p); br = AW'(p); bc = AW'(jj);
      end else if (p == N + 1) begin
        we = 1;
        cr = AW'(ii); cc = AW'(jj); cd = exp_c(ii, jj);
      end
    end
    return {bz, dn, re, ar, ac, re, br, bc, we, cr, cc, cd};
  endfunction

  logic [48:0] act_v, exp_v;
  assign act_v = {busy, done, a_en, a_row, a_col, b_en, b_row, b_col,
                  c_en, c_row, c_col, c_wd};

  always @(negedge clk) begin
    exp_v = exp_out(t);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs t=%0d got=%h want=%h", t, act_v, exp_v);
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_at = cyc - c0;
    end
    if (c_en) begin
      checks++;
      if (int'(c_row) != wr_cnt / N || int'(c_col) != wr_cnt % N) begin
        errors++;
        $display("FAIL raster got=(%0d,%0d) want=(%0d,%0d)",
                 c_row, c_col, wr_cnt / N, wr_cnt % N);
      end
      cm[c_row][c_col] = c_wd;
      wr_cnt++;
    end
  end

  task automatic chk(string name, longint got, longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk_prod(string name);
    int bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (cm[i][j] !== exp_c(i, j)) bad++;
    chk(name, bad, 0);
  endtask

  task automatic clr_counts();
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0; done_at = -1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) cm[i][j] = '0;
  endtask

  // start at cycle 0; optional abort / restart / reset at given cycles
  task automatic run_op(int ab_at, int rs1, int rs2, int rst_at);
    clr_counts();
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= D + 2; c++) begin
      if (ab_at > 0 && c == ab_at + 1) chk("busy_after_abort", busy, 0);
      if (ab_at > 0 && c > ab_at + 3) break;
      if (rst_at > 0 && c > rst_at + 4) break;
      if (rst_at > 0 && c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("outputs_in_reset", act_v, 0);
      end
      if (rst_at > 0 && c == rst_at + 2) rst_n = 1'b1;
      start = (c == rs1) || (c == rs2);
      abort = (c == ab_at);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  initial begin
    #2;
    chk("reset_outputs", act_v, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // identity A, random B
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = (i == j) ? 8'd1 : 8'd0;
        bm[i][j] = DW'($urandom_range(0, 255));
      end
    run_op(0, 0, 0, 0);
    begin
      int bad = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (cm[i][j] !== CW'(bm[i][j])) bad++;
      chk("identity_c_eq_b", bad, 0);
    end
    chk("writes_t1", wr_cnt, 100);
    chk("done_count_t1", done_cnt, 1);
    chk("done_cycle", done_at, 1201);
    chk("busy_cycles", busy_cnt, 1200);

    // all ones
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = 8'hFF;
        bm[i][j] = 8'hFF;
      end
    run_op(0, 0, 0, 0);
    chk("ff_c00", cm[0][0], 20'h9EC0A);
    chk("ff_c99", cm[9][9], 650250);
    chk("done_count_ff", done_cnt, 1);

    // random, start re-pulsed mid-run and in DONE
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = DW'($urandom_range(0, 255));
        bm[i][j] = DW'($urandom_range(0, 255));
      end
    run_op(0, 40, D, 0);
    chk("writes_restart", wr_cnt, 100);
    chk("done_restart", done_cnt, 1);
    chk_prod("c_restart");

    // abort in element 4 READ
    run_op(50, 0, 0, 0);
    chk("writes_abort", wr_cnt, 4);
    chk("done_abort", done_cnt, 0);
    run_op(0, 0, 0, 0);
    chk("writes_post_abort", wr_cnt, 100);
    chk_prod("c_post_abort");

    // reset mid-run
    run_op(0, 0, 0, 300);
    chk("done_reset", done_cnt, 0);
    run_op(0, 0, 0, 0);
    chk("writes_post_reset", wr_cnt, 100);
    chk("done_post_reset", done_cnt, 1);
    chk_prod("c_post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
